// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle shared by the arbiter's requester ports and its output.
//   master modport : drives payload + tvalid, receives tready
//   slave  modport : receives payload + tvalid, drives tready
// Payload fields: tdata, tstrb, tkeep, tlast, tid, tdest, tuser.
interface axi_stream_interface #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4,
  parameter int USER_W = 4
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic [ID_W-1:0]     tid;
  logic [DEST_W-1:0]   tdest;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin, packet-locked AXI-Stream arbiter with a single output register.
// When idle, the first valid requester after the last granted one (with
// wrap-around) is locked onto the output until its tlast beat is accepted.
//
// Ports:
//   clk       : sole clock, rising edge
//   rst       : synchronous, active-high reset
//   s[NUM_IN] : requester streams (slave modport; tready driven here)
//   m         : shared output stream (master modport), 1-cycle registered
//   grant_idx : index of the current / most recent grant
//   busy      : high while a packet is locked to an input
//   pkt_count : packets completed on m (tlast beats accepted), wraps at 16 bits
//
// DATA_W/ID_W/DEST_W/USER_W must match the connected interface instances.
module axis_rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = $clog2(NUM_IN),
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4,
  parameter int USER_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_stream_interface.slave   s [NUM_IN],
  axi_stream_interface.master  m,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy,
  output logic [15:0]          pkt_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic [ID_W-1:0]     tid;
    logic [DEST_W-1:0]   tdest;
    logic [USER_W-1:0]   tuser;
  } beat_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  beat_t             out_q;
  logic              out_valid_q;
  logic [15:0]       pkt_count_q;

  logic [NUM_IN-1:0] in_valid;
  beat_t             in_beat [NUM_IN];
  logic              out_free;
  logic              accept;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;

  // (base + off) mod NUM_IN for off in 1..NUM_IN.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_IN) sum -= NUM_IN;
    return IDX_W'(sum);
  endfunction

  // The output register can take a beat when empty or being drained.
  assign out_free = !out_valid_q || m.tready;
  assign accept   = (state_q == LOCKED) && in_valid[grant_q] && out_free;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign in_valid[i] = s[i].tvalid;
    assign in_beat[i]  = '{tdata: s[i].tdata, tstrb: s[i].tstrb,
                           tkeep: s[i].tkeep, tlast: s[i].tlast,
                           tid:   s[i].tid,   tdest: s[i].tdest,
                           tuser: s[i].tuser};
    // Only the locked owner ever sees tready; idle means nobody is ready.
    assign s[i].tready = (state_q == LOCKED) && (grant_q == IDX_W'(i)) && out_free;
  end

  // Round-robin search: iterate from lowest to highest priority so the
  // last hit (closest to ptr+1) wins without an early exit.
  always_comb begin : arbitrate
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      if (in_valid[wrap_idx(ptr_q, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_idx(ptr_q, k);
      end
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = LOCKED;
          ptr_d   = sel_idx;
          grant_d = sel_idx;
        end
      end
      LOCKED: begin
        // Lock is released only by an accepted tlast beat.
        if (accept && in_beat[grant_q].tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset here is synchronous: it is only a data condition sampled
  // on the rising edge, so it stays out of the sensitivity list.
  always_ff @(posedge clk) begin : state_reg
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_IN - 1);  // index 0 gets first priority
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  always_ff @(posedge clk) begin : out_reg
    if (rst) begin
      // NOTE: the payload register is reset as well, not just its valid
      // flag, because it is directly visible on m and must read as zero.
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= in_beat[grant_q];
    end else if (m.tready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin : pkt_cnt
    if (rst) begin
      pkt_count_q <= '0;
    end else if (out_valid_q && m.tready && out_q.tlast) begin
      pkt_count_q <= pkt_count_q + 16'd1;
    end
  end

  assign m.tvalid  = out_valid_q;
  assign m.tdata   = out_q.tdata;
  assign m.tstrb   = out_q.tstrb;
  assign m.tkeep   = out_q.tkeep;
  assign m.tlast   = out_q.tlast;
  assign m.tid     = out_q.tid;
  assign m.tdest   = out_q.tdest;
  assign m.tuser   = out_q.tuser;

  assign grant_idx = grant_q;
  assign busy      = (state_q == LOCKED);
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: randomized sources and sink,
// compared every cycle against a transaction-style reference model.
module tb_axis_rr_arbiter;
  localparam int NUM_IN = 4;
  localparam int IDX_W  = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [3:0]  user;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  beat_t             s_beat [NUM_IN];
  logic [NUM_IN-1:0] s_valid = '0;
  logic [NUM_IN-1:0] s_ready;
  logic              m_ready = 1'b1;
  beat_t             m_beat;
  logic [IDX_W-1:0]  grant_idx;
  logic              busy;
  logic [15:0]       pkt_count;

  axi_stream_interface s_if [NUM_IN] ();
  axi_stream_interface m_if ();

  for (genvar i = 0; i < NUM_IN; i++) begin : g_src
    assign s_if[i].tdata  = s_beat[i].data;
    assign s_if[i].tstrb  = s_beat[i].strb;
    assign s_if[i].tkeep  = s_beat[i].keep;
    assign s_if[i].tlast  = s_beat[i].last;
    assign s_if[i].tid    = s_beat[i].id;
    assign s_if[i].tdest  = s_beat[i].dest;
    assign s_if[i].tuser  = s_beat[i].user;
    assign s_if[i].tvalid = s_valid[i];
    assign s_ready[i]     = s_if[i].tready;
  end

  assign m_if.tready = m_ready;
  assign m_beat = '{data: m_if.tdata, strb: m_if.tstrb, keep: m_if.tkeep,
                    last: m_if.tlast, id: m_if.tid, dest: m_if.tdest,
                    user: m_if.tuser};

  axis_rr_arbiter #(.NUM_IN(NUM_IN)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (s_if),
    .m         (m_if),
    .grant_idx (grant_idx),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // ------------------------------------------------------------------ stimulus
  beat_t src_q [NUM_IN][$];
  int    gap_pct    = 0;    // chance an idle source holds off presenting
  int    ready_pct  = 100;  // chance the sink is ready in a cycle
  int    stall_left = 0;    // forced sink-stall cycles still to apply

  function automatic beat_t random_beat();
    beat_t b;
    b = {$urandom, $urandom};
    return b;
  endfunction

  task automatic add_pkt(input int src, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b      = random_beat();
      b.last = (k == len - 1);
      b.id   = 4'(src);
      b.user = 4'(k);
      src_q[src].push_back(b);
    end
  endtask

  // A source, once valid, holds its beat until it is accepted.
  task automatic present_sources();
    for (int i = 0; i < NUM_IN; i++) begin
      if (!s_valid[i]) begin
        if (src_q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
          s_valid[i] = 1'b1;
          s_beat[i]  = src_q[i][0];
        end else begin
          s_beat[i] = random_beat();
        end
      end
    end
  endtask

  task automatic drive_sink();
    if (stall_left > 0) begin
      m_ready = 1'b0;
      stall_left--;
    end else begin
      m_ready = ($urandom_range(99) < ready_pct);
    end
  endtask

  // ------------------------------------------------------------ reference model
  // owner = -1 when no packet is locked; last = most recently granted input.
  int    mdl_owner, mdl_last, mdl_grant, mdl_cnt;
  bit    mdl_ovalid;
  beat_t mdl_obeat;
  int    dut_grants[$];   // observed grant index at each start of a lock
  bit    prev_busy = 1'b0;

  task automatic model_reset();
    mdl_owner  = -1;
    mdl_last   = NUM_IN - 1;
    mdl_grant  = 0;
    mdl_cnt    = 0;
    mdl_ovalid = 1'b0;
    mdl_obeat  = '0;
  endtask

  // One clock cycle: compare at the falling edge, advance model, then
  // update stimulus just after the rising edge.
  task automatic step();
    int                owner_n, last_n, grant_n, cnt_n;
    bit                ovalid_n, out_free, acc;
    beat_t             obeat_n;
    logic [NUM_IN-1:0] exp_ready;

    @(negedge clk);
    out_free  = !mdl_ovalid || m_ready;
    exp_ready = '0;
    if (mdl_owner >= 0 && out_free) exp_ready[mdl_owner] = 1'b1;
    check("s_tready", s_ready, exp_ready);
    check("m_tvalid", m_if.tvalid, mdl_ovalid);
    if (mdl_ovalid) check("m_payload", m_beat, mdl_obeat);
    check("busy", busy, mdl_owner >= 0);
    check("grant_idx", grant_idx, mdl_grant);
    check("pkt_count", pkt_count, mdl_cnt);
    if (busy && !prev_busy) dut_grants.push_back(int'(grant_idx));
    prev_busy = busy;

    acc      = (mdl_owner >= 0) && s_valid[mdl_owner] && out_free;
    owner_n  = mdl_owner;
    last_n   = mdl_last;
    grant_n  = mdl_grant;
    ovalid_n = mdl_ovalid;
    obeat_n  = mdl_obeat;
    cnt_n    = mdl_cnt;

    if (mdl_ovalid && m_ready && mdl_obeat.last) cnt_n = (mdl_cnt + 1) % 65536;
    if (acc) begin
      ovalid_n = 1'b1;
      obeat_n  = s_beat[mdl_owner];
    end else if (m_ready) begin
      ovalid_n = 1'b0;
    end

    if (mdl_owner < 0) begin
      for (int k = 1; k <= NUM_IN; k++) begin
        if (owner_n < 0 && s_valid[(mdl_last + k) % NUM_IN]) begin
          owner_n = (mdl_last + k) % NUM_IN;
          last_n  = owner_n;
          grant_n = owner_n;
        end
      end
    end else if (acc && s_beat[mdl_owner].last) begin
      owner_n = -1;
    end

    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
      for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
      s_valid = '0;
    end else begin
      if (acc) begin
        void'(src_q[mdl_owner].pop_front());
        s_valid[mdl_owner] = 1'b0;
      end
      mdl_owner  = owner_n;
      mdl_last   = last_n;
      mdl_grant  = grant_n;
      mdl_ovalid = ovalid_n;
      mdl_obeat  = obeat_n;
      mdl_cnt    = cnt_n;
    end
    present_sources();
    drive_sink();
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = (mdl_owner < 0) && !mdl_ovalid && (s_valid == '0);
    for (int i = 0; i < NUM_IN; i++) if (src_q[i].size() != 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!all_idle() && n < max_cycles) begin
      step();
      n++;
    end
    check({tag, "_drain_in_budget"}, (n < max_cycles), 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ------------------------------------------------------------------ sequence
  int exp_order [5] = '{0, 1, 2, 3, 0};
  int base_cnt;

  initial begin
    for (int i = 0; i < NUM_IN; i++) s_beat[i] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step();                 // outputs checked against reset values
    rst = 1'b0;
    repeat (3) step();

    // Single requester, 3-beat packet, sink always ready.
    dut_grants.delete();
    add_pkt(2, 3);
    present_sources();
    drain("single", 50);
    check("single_grant_idx", grant_idx, 2);
    check("single_pkt_count", pkt_count, 1);
    check("single_n_grants", dut_grants.size(), 1);

    // All four requesting 1-beat packets right after reset.
    do_reset();
    dut_grants.delete();
    add_pkt(0, 1); add_pkt(0, 1);
    add_pkt(1, 1); add_pkt(2, 1); add_pkt(3, 1);
    present_sources();
    drain("rr", 50);
    for (int k = 0; k < 5; k++)
      check($sformatf("rr_order_%0d", k),
            (k < dut_grants.size()) ? dut_grants[k] : 99, exp_order[k]);
    check("rr_pkt_count", pkt_count, 5);

    // Five-cycle sink stall in the middle of a 6-beat packet.
    add_pkt(1, 6);
    present_sources();
    repeat (3) step();
    stall_left = 5;
    drain("stall", 60);
    check("stall_pkt_count", pkt_count, 6);

    // Packet lock: s[1] requests while s[0] is mid-packet.
    dut_grants.delete();
    add_pkt(0, 4);
    present_sources();
    repeat (2) step();
    add_pkt(1, 2);
    present_sources();
    drain("lock", 60);
    check("lock_first", (dut_grants.size() > 0) ? dut_grants[0] : 99, 0);
    check("lock_second", (dut_grants.size() > 1) ? dut_grants[1] : 99, 1);

    // Reset while beat 3 of a 4-beat packet is being offered.
    add_pkt(1, 4);
    present_sources();
    repeat (3) step();
    do_reset();
    check("rst_m_tvalid", m_if.tvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pkt_count", pkt_count, 0);
    dut_grants.delete();
    add_pkt(3, 1);
    add_pkt(1, 1);
    present_sources();
    drain("post_rst", 50);
    check("post_rst_first_grant", (dut_grants.size() > 0) ? dut_grants[0] : 99, 1);

    // Randomized traffic with source gaps and sink backpressure.
    gap_pct   = 30;
    ready_pct = 70;
    base_cnt  = int'(pkt_count);
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 50; p++) add_pkt($urandom_range(NUM_IN - 1), $urandom_range(1, 5));
      present_sources();
      drain($sformatf("rand_%0d", r), 5000);
    end
    check("rand_pkt_count", pkt_count, (base_cnt + 200) % 65536);

    // Counter wrap: preload near the top, then complete two packets.
    gap_pct   = 0;
    ready_pct = 100;
    step();
    force dut.pkt_count_q = 16'hFFFE;
    #1;
    release dut.pkt_count_q;
    mdl_cnt = 16'hFFFE;
    add_pkt(2, 1);
    present_sources();
    drain("wrap_a", 50);
    check("wrap_ffff", pkt_count, 16'hFFFF);
    add_pkt(0, 2);
    present_sources();
    drain("wrap_b", 50);
    check("wrap_zero", pkt_count, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter NUM_IN, default 4, giving the number of AXI-Stream requester ports (legal range 2..8).
REQ-002 The block SHALL have parameter IDX_W, default $clog2(NUM_IN), giving the width of the grant index.

Ports (one clock; reset synchronous, active-high):
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s[NUM_IN]  axi_stream_interface.slave  bundle  requester streams (tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid in; tready out).
REQ-006 m  axi_stream_interface.master  bundle  shared output stream.
REQ-007 grant_idx  output  IDX_W  index of the currently or most recently granted input.
REQ-008 busy  output  1  high while a packet is locked to an input.
REQ-009 pkt_count  output  16  count of packets completed on m (tlast beats accepted by the downstream).

Function
REQ-010 The block SHALL use a two-state FSM: IDLE (no lock) and LOCKED (one input owns the output until its tlast beat is accepted).
REQ-011 In IDLE, the block SHALL select the first input with tvalid=1, searching from (ptr+1) mod NUM_IN upward with wrap-around, where ptr is the last granted index.
REQ-012 On selection, the FSM SHALL enter LOCKED next cycle, with grant_idx and ptr set to the selected index; if no input is valid, it SHALL stay in IDLE.
REQ-013 In LOCKED, s[grant_idx].tready SHALL equal out_free = (!m.tvalid || m.tready); tready of all other inputs SHALL be 0.
REQ-014 In IDLE, all s[i].tready SHALL be 0.
REQ-015 The output SHALL be a single register stage: on s[g].tvalid && s[g].tready, all payload fields SHALL be copied to m and m.tvalid set to 1 on the next edge, giving 1-cycle latency.
REQ-016 m.tvalid SHALL clear when m.tready=1 and no new beat is loaded in the same cycle; when m.tvalid=1 and m.tready=0, the m payload SHALL remain stable.
REQ-017 When an accepted input beat has tlast=1, the FSM SHALL return to IDLE on the next edge; at most one lock-free bubble cycle SHALL separate packets.
REQ-018 Arbitration SHALL NOT interrupt a packet: a new grant occurs only from IDLE.
REQ-019 pkt_count SHALL increment by 1 on each m.tvalid && m.tready && m.tlast, wrapping from 0xFFFF to 0.
REQ-020 busy SHALL be 1 exactly when the FSM is in LOCKED.
REQ-021 When only one input is requesting, it SHALL be regranted after each of its packets, one IDLE cycle apart.
REQ-022 Data throughput in LOCKED with m.tready held at 1 SHALL be one beat per cycle.

Reset
REQ-023 On rst=1 at a clock edge: FSM=IDLE, ptr=NUM_IN-1 (so index 0 has first priority), grant_idx=0, busy=0, m.tvalid=0, m payload fields=0, pkt_count=0, all s[i].tready=0.
REQ-024 Reset asserted mid-packet SHALL discard the partial packet and the output register contents without emitting further beats; there is no recovery of the partial packet.

Verification
REQ-025 Single input: s[2] sends a 3-beat packet with m.tready=1 -> beats appear on m at cycles +2..+4 after the first tvalid, m.tlast on beat 3, pkt_count=1, grant_idx=2.
REQ-026 All four inputs hold 1-beat packets continuously after reset -> grant order 0,1,2,3,0, and pkt_count=5 after the fifth packet.
REQ-027 Backpressure: m.tready=0 for 5 cycles mid-packet -> m payload stable, granted tready=0, no beat lost or duplicated; order is preserved after release.
REQ-028 Packet lock: s[0] is in a 4-beat packet when s[1] raises tvalid -> s[1].tready stays 0 until s[0]'s tlast is accepted, then s[1] is granted after 1 IDLE cycle.
REQ-029 Reset during beat 2 of a 4-beat packet -> next cycle m.tvalid=0, busy=0, pkt_count=0, and the next grant goes to the lowest-index valid input.
REQ-030 pkt_count preloaded near wrap by 65535 packets, then 1 more packet -> pkt_count=0.
